// File: rtl/tdm_demux_1x32.sv
// Receive-side 1-to-32 TDM demultiplexer: serial bits fill a shadow word one
// channel per accepted beat, and a completed word is published to dout as a frame.
module tdm_demux_1x32 #(
   parameter int N_CH  = 32,
   parameter int SEL_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic [SEL_W-1:0] sel_out,
   output logic             busy,
   output logic [N_CH-1:0]  dout,
   output logic             frame_valid
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CAPTURE = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

   logic [1:0]       state_reg, state_next;
   logic [SEL_W-1:0] ch_reg, ch_next;
   logic [N_CH-1:0]  shadow_reg;
   logic [N_CH-1:0]  dout_reg;
   logic             frame_valid_reg;
   logic             take;
   logic             clear_shadow;

   // Abort wins over a coincident beat, so the beat never lands in the shadow word.
   assign take         = (state_reg == ST_CAPTURE) & din_valid & ~abort;
   assign clear_shadow = start & ((state_reg == ST_IDLE) | (state_reg == ST_DONE));

   always_comb begin
      state_next = state_reg;
      ch_next    = ch_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_CAPTURE;
               ch_next    = '0;
            end
         end
         ST_CAPTURE: begin
            if (abort) begin
               state_next = ST_IDLE;
               ch_next    = '0;
            end else if (take) begin
               if (ch_reg == LAST_CH) begin
                  state_next = ST_DONE;
                  ch_next    = '0;
               end else begin
                  ch_next = ch_reg + 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_next = start ? ST_CAPTURE : ST_IDLE;
            ch_next    = '0;
         end
         default: begin
            state_next = ST_IDLE;
            ch_next    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         ch_reg    <= '0;
      end else begin
         state_reg <= state_next;
         ch_reg    <= ch_next;
      end
   end

   // One flop per slot; each slot only loads when the channel counter points at it.
   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_slot
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               shadow_reg[gi] <= 1'b0;
            end else if (clear_shadow) begin
               shadow_reg[gi] <= 1'b0;
            end else if (take && (ch_reg == SEL_W'(gi))) begin
               shadow_reg[gi] <= din;
            end
         end
      end
   endgenerate

   // Publishing happens on the edge that leaves DONE, so the pulse and the new
   // word appear together one cycle after the last beat's edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_reg        <= '0;
         frame_valid_reg <= 1'b0;
      end else begin
         frame_valid_reg <= (state_reg == ST_DONE);
         if (state_reg == ST_DONE) begin
            dout_reg <= shadow_reg;
         end
      end
   end

   assign din_ready   = (state_reg == ST_CAPTURE);
   assign busy        = (state_reg == ST_CAPTURE);
   assign sel_out     = busy ? ch_reg : '0;
   assign dout        = dout_reg;
   assign frame_valid = frame_valid_reg;

endmodule

// File: tb/tb_tdm_demux_1x32.sv
// Scoreboard bench for tdm_demux_1x32: the driver queues each completed word,
// and a negedge monitor checks every published frame and that dout holds otherwise.
module tb_tdm_demux_1x32;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic        din;
   logic        din_valid;
   logic        din_ready;
   logic [4:0]  sel_out;
   logic        busy;
   logic [31:0] dout;
   logic        frame_valid;

   int          vectors = 0;
   int          miscompares = 0;
   int          cycle = 0;
   logic [31:0] exp_q[$];
   int          fv_q[$];
   logic [31:0] cur_dout = '0;

   always #5 clk = ~clk;

   tdm_demux_1x32 dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .din         (din),
      .din_valid   (din_valid),
      .din_ready   (din_ready),
      .sel_out     (sel_out),
      .busy        (busy),
      .dout        (dout),
      .frame_valid (frame_valid)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Monitor: the model of dout is "last frame popped from the scoreboard".
   always @(negedge clk) begin
      cycle++;
      if (rst) begin
         exp_q.delete();
         cur_dout = '0;
         chk("dout_in_reset", dout, 32'h0);
         chk("fv_in_reset", {31'b0, frame_valid}, 32'h0);
      end else if (frame_valid) begin
         fv_q.push_back(cycle);
         if (exp_q.size() == 0) begin
            chk("fv_unexpected", {31'b0, frame_valid}, 32'h0);
         end else begin
            cur_dout = exp_q.pop_front();
            chk("frame", dout, cur_dout);
         end
      end else begin
         chk("dout_hold", dout, cur_dout);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      start     = 1'b0;
      din_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   // Drives one frame starting from IDLE or DONE. gap: 0 none, >0 every gap-th
   // cycle low, -1 random. abort_at / start_at: channel index, or -1 for never.
   task automatic run_frame(input logic [31:0] w, input int gap, input int abort_at,
                            input int start_at, input bit keep_start);
      int i   = 0;
      int cyc = 0;
      bit v;
      start = 1'b1;
      step();
      start = keep_start;
      while (i < 32) begin
         chk("din_ready", {31'b0, din_ready}, 32'h1);
         chk("sel_out", {27'b0, sel_out}, i);
         if (abort_at == i) begin
            abort     = 1'b1;
            din_valid = 1'b1;
            din       = 1'b1;
            step();
            abort     = 1'b0;
            din_valid = 1'b0;
            start     = 1'b0;
            chk("abort_busy", {31'b0, busy}, 32'h0);
            chk("abort_ready", {31'b0, din_ready}, 32'h0);
            return;
         end
         if (gap > 0)       v = ((cyc % gap) != (gap - 1));
         else if (gap < 0)  v = ($urandom_range(0, 3) != 0);
         else               v = 1'b1;
         din_valid = v;
         din       = v ? w[i] : 1'($urandom);
         start     = keep_start | (start_at == i);
         step();
         if (v) i++;
         cyc++;
      end
      exp_q.push_back(w);
      din_valid = 1'b0;
      if (!keep_start) start = 1'b0;
   endtask

   initial begin
      int          t0;
      int          n;
      logic [31:0] w;
      rst = 1'b1; start = 1'b0; abort = 1'b0; din = 1'b0; din_valid = 1'b0;
      step();
      step();
      chk("rst_dout", dout, 32'h0);
      chk("rst_ready", {31'b0, din_ready}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_sel", {27'b0, sel_out}, 32'h0);
      rst = 1'b0;
      step();

      // One-hot scan
      for (int k = 0; k < 32; k++) begin
         w = 32'h1 << k;
         run_frame(w, 0, -1, -1, 1'b0);
         idle(2);
      end

      // Asynchronous reset mid-capture at ch=12
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         din_valid = 1'b1;
         din       = 1'b1;
         step();
      end
      chk("t1_sel12", {27'b0, sel_out}, 32'd12);
      #2 rst = 1'b1;
      #1;
      chk("t1_dout", dout, 32'h0);
      chk("t1_ready", {31'b0, din_ready}, 32'h0);
      chk("t1_sel", {27'b0, sel_out}, 32'h0);
      din_valid = 1'b0;
      step();
      rst = 1'b0;
      step();

      // Pattern with gaps every third cycle
      run_frame(32'hA5C3_0F96, 3, -1, -1, 1'b0);
      idle(3);

      // Abort then a clean frame
      run_frame(32'hFFFF_FFFF, 0, 10, -1, 1'b0);
      idle(3);
      run_frame(32'h1234_5678, 0, -1, -1, 1'b0);
      idle(3);

      // Back-to-back frames with start held
      n = fv_q.size();
      run_frame(32'hDEAD_BEEF, 0, -1, -1, 1'b1);
      run_frame(32'h0000_0001, 0, -1, -1, 1'b0);
      idle(3);
      chk("b2b_count", fv_q.size() - n, 32'd2);
      if (fv_q.size() - n == 2) chk("b2b_spacing", fv_q[$] - fv_q[$-1], 32'd33);

      // Start pulse in CAPTURE at ch=20 is ignored
      run_frame(32'h0F0F_3C3C, 0, -1, 20, 1'b0);
      idle(3);

      // Randomised frames, gaps and aborts
      for (int r = 0; r < 40; r++) begin
         w = $urandom;
         run_frame(w, -1, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31)) : -1,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1,
                   1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 4)));
      end
      idle(2);

      t0 = 0;
      while (exp_q.size() != 0 && t0 < 100) begin
         step();
         t0++;
      end
      chk("drain", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
